mem_wb_skid_stage: RTL

// Parametrised MEM->WB pipeline register, the next generation of the fixed-width MEM/WB latch.

---
 rtl/mem_wb_skid_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_skid_stage.sv
`timescale 1ns/1ps
// MEM->WB register with a 2-entry skid buffer (SKID_EN=1) or a single entry (SKID_EN=0); 1-cycle latency when empty.
// Backpressure: SKID_EN=1 gives a registered Ready_MEM (low only when full); SKID_EN=0 gives Ready_MEM = !Valid_WB | Ready_WB.
module mem_wb_skid_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit SKID_EN        = 1'b1
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Flush,
  input  logic                      Valid_MEM,
  output logic                      Ready_MEM,
  input  logic                      RegWrite_MEM,
  input  logic                      MemtoReg_MEM,
  input  logic [DATA_WIDTH-1:0]     Read_Data_MEM,
  input  logic [DATA_WIDTH-1:0]     ALU_Result_MEM,
  input  logic [REG_ADDR_WIDTH-1:0] Write_Register_MEM,
  output logic                      Valid_WB,
  input  logic                      Ready_WB,
  output logic                      RegWrite_WB,
  output logic                      MemtoReg_WB,
  output logic [DATA_WIDTH-1:0]     Read_Data_WB,
  output logic [DATA_WIDTH-1:0]     ALU_Result_WB,
  output logic [REG_ADDR_WIDTH-1:0] Write_Register_WB,
  output logic [DATA_WIDTH-1:0]     Write_Data_WB,
  output logic [1:0]                Occupancy
);

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_to_reg;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [REG_ADDR_WIDTH-1:0] wr_reg;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_in_ent;
  logic   w_in;
  logic   w_out;
  logic   w_load_main_in;
  logic   w_load_main_skid;
  logic   w_load_skid;

  assign w_in_ent = {RegWrite_MEM, MemtoReg_MEM, Read_Data_MEM, ALU_Result_MEM, Write_Register_MEM};
  assign w_in     = Valid_MEM & Ready_MEM;
  assign w_out    = Valid_WB & Ready_WB;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (Flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in && w_out) begin
            w_load_main_in = 1'b1;
          end else if (w_in) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_out) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_ent;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_ent;
      end
    end
  end

  // Registered ready breaks the Ready_WB -> Ready_MEM timing path.
  generate
    if (SKID_EN) begin : g_skid
      logic r_ready_mem;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_ready_mem <= 1'b1;
        end else begin
          r_ready_mem <= (w_state_nxt != ST_FULL);
        end
      end
      assign Ready_MEM = r_ready_mem;
    end else begin : g_single
      assign Ready_MEM = ~Valid_WB | Ready_WB;
    end
  endgenerate

  assign Valid_WB          = (r_state != ST_EMPTY);
  assign RegWrite_WB       = r_main.reg_write & Valid_WB;
  assign MemtoReg_WB       = r_main.mem_to_reg;
  assign Read_Data_WB      = r_main.read_data;
  assign ALU_Result_WB     = r_main.alu_result;
  assign Write_Register_WB = r_main.wr_reg;
  assign Write_Data_WB     = r_main.mem_to_reg ? r_main.read_data : r_main.alu_result;
  assign Occupancy         = r_state;

endmodule
